// File: rtl/studio_membus.sv
// ============================================================================
// studio_membus
// ----------------------------------------------------------------------------
// System memory bus for the Studio II core family. It holds the BIOS ROM,
// the cartridge ROM and the work/display RAM. It also decodes CPU accesses
// and arbitrates video DMA fetches against the CPU. BIOS and cartridge
// images are loaded from the HPS ioctl download stream.
//
// Bus priority: download > DMA > CPU. The three arrays share a single read
// address, because the CPU and DMA are never served in the same cycle. The
// only writers are the loader and the CPU, and they are mutually exclusive
// for the same reason.
//
// Optional feature (compile-time macro MEMBUS_CART_MIRROR_EN):
//   defined   - cartridge reads use (offset mod cart_len), so small images
//               mirror across the window; reads with cart_len == 0 give FF.
//   undefined - cartridge reads return raw array contents at the offset.
//
// BIOS_FN names the BIOS image supplied through the FPGA memory-init flow.
// When it is empty, the BIOS reads as zero until the first BIOS byte has
// been downloaded.
//
// Ports
//   clk, resetq          system clock, synchronous active-low reset
//   ioctl_download       download active
//   ioctl_index          download target (BIOS_INDEX / CART_INDEX)
//   ioctl_wr             download byte strobe
//   ioctl_addr           download byte address
//   ioctl_dout           download byte
//   cpu_rd, cpu_wr       CPU read / write request (both high -> write)
//   cpu_a, cpu_d         CPU address / write data
//   cpu_q                CPU read data, one cycle after the accepted read
//   cpu_wait             CPU must hold its request (combinational)
//   dma_req, dma_a       video DMA read request / address
//   dma_ack              DMA address accepted this cycle
//   dma_valid, dma_q     DMA read data, one cycle after dma_ack
//   cart_loaded          valid cartridge image present
//   cart_len             bytes spanned by the loaded cart (highest addr + 1)
//   load_overflow        a download byte was dropped (address out of range)
// ============================================================================
module studio_membus #(
   parameter int          BIOS_AW    = 11,
   parameter int          CART_AW    = 11,
   parameter int          RAM_AW     = 9,
   parameter logic [15:0] BIOS_BASE  = 16'h0000,
   parameter logic [15:0] CART_BASE  = 16'h0400,
   parameter logic [15:0] RAM_BASE   = 16'h0800,
   parameter logic [7:0]  BIOS_INDEX = 8'h00,
   parameter logic [7:0]  CART_INDEX = 8'h01,
   parameter string       BIOS_FN    = ""
) (
   input  logic               clk,
   input  logic               resetq,
   input  logic               ioctl_download,
   input  logic [7:0]         ioctl_index,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   input  logic               cpu_rd,
   input  logic               cpu_wr,
   input  logic [15:0]        cpu_a,
   input  logic [7:0]         cpu_d,
   output logic [7:0]         cpu_q,
   output logic               cpu_wait,
   input  logic               dma_req,
   input  logic [15:0]        dma_a,
   output logic               dma_ack,
   output logic               dma_valid,
   output logic [7:0]         dma_q,
   output logic               cart_loaded,
   output logic [CART_AW:0]   cart_len,
   output logic               load_overflow
);

   localparam bit BIOS_BLANK = (BIOS_FN == "");

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_BIOS = 2'd1,
      ST_LOAD_CART = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   // A region matches when the address bits above its window equal its base.
   function automatic logic f_hit(input logic [15:0] a, input logic [15:0] base,
                                  input int aw);
      logic [15:0] m;
      m = 16'((32'd1 << aw) - 32'd1);
      return ((a & ~m) == base);
   endfunction

`ifdef MEMBUS_CART_MIRROR_EN
   // Restoring remainder: try len<<k for k from the top down and subtract at
   // most once per power of two. The offset is below 2^CART_AW <= len<<CART_AW,
   // so the result ends up below len.
   function automatic logic [CART_AW-1:0] f_cart_mod(input logic [CART_AW-1:0] off,
                                                     input logic [CART_AW:0]   len);
      logic [2*CART_AW:0] rem;
      logic [2*CART_AW:0] div;
      rem = (2*CART_AW+1)'(off);
      for (int k = CART_AW - 1; k >= 0; k--) begin
         div = {{CART_AW{1'b0}}, len} << k;
         if (rem >= div) rem = rem - div;
      end
      return rem[CART_AW-1:0];
   endfunction
`endif

   // -------------------------------------------------------------------------
   // Storage (contents survive reset)
   // -------------------------------------------------------------------------
   logic [7:0] r_bios_mem [2**BIOS_AW];
   logic [7:0] r_cart_mem [2**CART_AW];
   logic [7:0] r_ram_mem  [2**RAM_AW];
   logic       r_bios_written = 1'b0;

   // -------------------------------------------------------------------------
   // Loader control
   // -------------------------------------------------------------------------
   state_t      r_state;
   logic        r_was_cart;
   logic        r_dl_block;      // download was still high across reset

   logic        w_ldr_idle;
   logic        w_dl_go;
   logic        w_start_bios;
   logic        w_start_cart;
   logic        w_in_bios_ld;
   logic        w_in_cart_ld;
   logic        w_bios_fit;
   logic        w_cart_fit;
   logic        w_ld_bios_wr;
   logic        w_ld_cart_wr;
   logic        w_ld_drop;
   logic [CART_AW:0] w_len_byte;
   logic [CART_AW:0] w_len_base;
   logic [CART_AW:0] w_len_next;

   // A download that was in flight when reset hit is not a fresh download.
   // The loader stays busy until that download falls.
   assign w_ldr_idle   = (r_state == ST_IDLE) & ~(r_dl_block & ioctl_download);
   assign w_dl_go      = w_ldr_idle & ioctl_download;
   assign w_start_bios = w_dl_go & (ioctl_index == BIOS_INDEX);
   assign w_start_cart = w_dl_go & (ioctl_index == CART_INDEX) & ~w_start_bios;

   // Bytes that arrive in the same cycle as the start are already accepted.
   assign w_in_bios_ld = (r_state == ST_LOAD_BIOS) | w_start_bios;
   assign w_in_cart_ld = (r_state == ST_LOAD_CART) | w_start_cart;

   assign w_bios_fit   = ((ioctl_addr >> BIOS_AW) == 25'd0);
   assign w_cart_fit   = ((ioctl_addr >> CART_AW) == 25'd0);

   assign w_ld_bios_wr = resetq & ioctl_wr & w_in_bios_ld & w_bios_fit;
   assign w_ld_cart_wr = resetq & ioctl_wr & w_in_cart_ld & w_cart_fit;
   assign w_ld_drop    = resetq & ioctl_wr &
                         ((w_in_bios_ld & ~w_bios_fit) | (w_in_cart_ld & ~w_cart_fit));

   // The cart span restarts from zero when a cart load begins.
   assign w_len_byte = {1'b0, ioctl_addr[CART_AW-1:0]} + (CART_AW+1)'(1);
   assign w_len_base = w_start_cart ? '0 : cart_len;
   assign w_len_next = (w_ld_cart_wr && (w_len_byte > w_len_base)) ? w_len_byte : w_len_base;

   always_ff @(posedge clk) begin
      if (!resetq) begin
         r_state       <= ST_IDLE;
         r_was_cart    <= 1'b0;
         r_dl_block    <= ioctl_download;
         cart_loaded   <= 1'b0;
         cart_len      <= '0;
         load_overflow <= 1'b0;
      end else begin
         if (!ioctl_download) r_dl_block <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_start_bios) begin
                  r_state    <= ST_LOAD_BIOS;
                  r_was_cart <= 1'b0;
               end else if (w_start_cart) begin
                  r_state    <= ST_LOAD_CART;
                  r_was_cart <= 1'b1;
               end
            end
            ST_LOAD_BIOS, ST_LOAD_CART: begin
               if (!ioctl_download) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               if (r_was_cart) cart_loaded <= (cart_len != '0);
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_start_cart) cart_loaded <= 1'b0;

         if (w_start_bios || w_start_cart) load_overflow <= w_ld_drop;
         else if (w_ld_drop)               load_overflow <= 1'b1;

         if (w_start_cart || w_ld_cart_wr) cart_len <= w_len_next;
      end
   end

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   logic w_cpu_rd_go;
   logic w_ram_we;

   assign cpu_wait    = ~w_ldr_idle | dma_req;
   assign dma_ack     = dma_req & w_ldr_idle & resetq;
   assign w_cpu_rd_go = cpu_rd & ~cpu_wr & ~cpu_wait;
   assign w_ram_we    = resetq & cpu_wr & ~cpu_wait & f_hit(cpu_a, RAM_BASE, RAM_AW);

   // -------------------------------------------------------------------------
   // Read decode (p0): DMA owns the read port whenever it requests
   // -------------------------------------------------------------------------
   logic [15:0] w_rd_a;
   logic        w_hit_ram;
   logic        w_hit_cart;
   logic        w_hit_bios;
   logic [7:0]  w_bios_byte;
   logic [7:0]  w_cart_byte;
   logic [7:0]  w_rd_data;

   assign w_rd_a     = dma_req ? dma_a : cpu_a;
   assign w_hit_ram  = f_hit(w_rd_a, RAM_BASE, RAM_AW);
   assign w_hit_cart = f_hit(w_rd_a, CART_BASE, CART_AW) & cart_loaded;
   assign w_hit_bios = f_hit(w_rd_a, BIOS_BASE, BIOS_AW);

   assign w_bios_byte = (BIOS_BLANK && !r_bios_written) ? 8'h00
                                                        : r_bios_mem[w_rd_a[BIOS_AW-1:0]];

`ifdef MEMBUS_CART_MIRROR_EN
   // The remainder chain settles within the address cycle, so mirrored reads
   // keep the same one-cycle latency as every other read.
   logic [CART_AW-1:0] w_cart_off;
   assign w_cart_off  = f_cart_mod(w_rd_a[CART_AW-1:0], cart_len);
   assign w_cart_byte = (cart_len == '0) ? 8'hFF : r_cart_mem[w_cart_off];
`else
   assign w_cart_byte = r_cart_mem[w_rd_a[CART_AW-1:0]];
`endif

   always_comb begin
      w_rd_data = 8'hFF;
      if (w_hit_ram)       w_rd_data = r_ram_mem[w_rd_a[RAM_AW-1:0]];
      else if (w_hit_cart) w_rd_data = w_cart_byte;
      else if (w_hit_bios) w_rd_data = w_bios_byte;
   end

   // -------------------------------------------------------------------------
   // Memory writes: loader into BIOS/cart, CPU into RAM only
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_ld_bios_wr) begin
         r_bios_mem[ioctl_addr[BIOS_AW-1:0]] <= ioctl_dout;
         r_bios_written <= 1'b1;
      end
      if (w_ld_cart_wr) r_cart_mem[ioctl_addr[CART_AW-1:0]] <= ioctl_dout;
      if (w_ram_we)     r_ram_mem[cpu_a[RAM_AW-1:0]]        <= cpu_d;
   end

   // -------------------------------------------------------------------------
   // Read data register (p1): cpu_q / dma_q hold until their next read
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetq) begin
         cpu_q     <= 8'h00;
         dma_q     <= 8'h00;
         dma_valid <= 1'b0;
      end else begin
         dma_valid <= dma_ack;
         if (dma_ack)     dma_q <= w_rd_data;
         if (w_cpu_rd_go) cpu_q <= w_rd_data;
      end
   end

endmodule

// File: tb/tb_studio_membus.sv
module tb_studio_membus;

   // The cart window at 16'h0400 is aligned to a 1 KiB window, so the bench
   // uses CART_AW = 10; the first out-of-range download address is 1024.
   localparam int CART_AW = 10;

   logic              clk = 1'b0;
   logic              resetq;
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              cpu_rd;
   logic              cpu_wr;
   logic [15:0]       cpu_a;
   logic [7:0]        cpu_d;
   logic [7:0]        cpu_q;
   logic              cpu_wait;
   logic              dma_req;
   logic [15:0]       dma_a;
   logic              dma_ack;
   logic              dma_valid;
   logic [7:0]        dma_q;
   logic              cart_loaded;
   logic [CART_AW:0]  cart_len;
   logic              load_overflow;

   int n_checks = 0;
   int n_errs   = 0;

   studio_membus #(.CART_AW(CART_AW)) dut (
      .clk            (clk),
      .resetq         (resetq),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .cpu_rd         (cpu_rd),
      .cpu_wr         (cpu_wr),
      .cpu_a          (cpu_a),
      .cpu_d          (cpu_d),
      .cpu_q          (cpu_q),
      .cpu_wait       (cpu_wait),
      .dma_req        (dma_req),
      .dma_a          (dma_a),
      .dma_ack        (dma_ack),
      .dma_valid      (dma_valid),
      .dma_q          (dma_q),
      .cart_loaded    (cart_loaded),
      .cart_len       (cart_len),
      .load_overflow  (load_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_wr = 1'b1; cpu_a = a; cpu_d = d;
      tick();
      cpu_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      cpu_rd = 1'b1; cpu_a = a;
      tick();
      cpu_rd = 1'b0;
   endtask

   task automatic dl_start(input logic [7:0] idx);
      ioctl_index = idx; ioctl_download = 1'b1;
      tick();
   endtask

   task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic dl_end();
      ioctl_download = 1'b0;
      tick();   // LOAD -> DONE
      tick();   // DONE -> IDLE
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetq = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = 8'h00; cpu_rd = 1'b0; cpu_wr = 1'b0;
      cpu_a = 16'h0000; cpu_d = 8'h00; dma_req = 1'b0; dma_a = 16'h0000;

      // ---- reset state
      tick(); tick();
      chk("rst_cpu_wait", cpu_wait, 1'b0);
      chk("rst_cpu_q", cpu_q, 8'h00);
      chk("rst_dma_valid", dma_valid, 1'b0);
      chk("rst_cart_loaded", cart_loaded, 1'b0);
      chk("rst_cart_len", cart_len, 0);
      chk("rst_overflow", load_overflow, 1'b0);
      dma_req = 1'b1; #1;
      chk("rst_dma_ack_gated", dma_ack, 1'b0);
      chk("rst_wait_dma", cpu_wait, 1'b1);
      dma_req = 1'b0;
      resetq = 1'b1;
      tick();

      // ---- CPU RAM write / read
      cpu_wr = 1'b1; cpu_a = 16'h0810; cpu_d = 8'hA5; #1;
      chk("wr_wait", cpu_wait, 1'b0);
      tick(); cpu_wr = 1'b0;
      cpu_rd = 1'b1; cpu_a = 16'h0810; #1;
      chk("rd_wait", cpu_wait, 1'b0);
      tick(); cpu_rd = 1'b0;
      chk("ram_0810", cpu_q, 8'hA5);
      cpu_write(16'h09FF, 8'h3C);
      cpu_read(16'h09FF);
      chk("ram_top_09ff", cpu_q, 8'h3C);
      cpu_write(16'h0A00, 8'h12);
      cpu_read(16'h0A00);
      chk("unmapped_0a00", cpu_q, 8'hFF);
      tick();
      chk("cpu_q_hold", cpu_q, 8'hFF);
      cpu_read(16'h0405);
      chk("bios_blank_0405", cpu_q, 8'h00);

      // ---- 512-byte cart download
      dl_start(8'h01);
      chk("ld_wait", cpu_wait, 1'b1);
      for (int i = 0; i < 512; i++) dl_byte(25'(i), 8'(i));
      chk("ld_not_loaded_yet", cart_loaded, 1'b0);
      dl_end();
      chk("cart_loaded", cart_loaded, 1'b1);
      chk("cart_len_512", cart_len, 512);
      chk("no_overflow", load_overflow, 1'b0);
      chk("idle_wait", cpu_wait, 1'b0);
      cpu_read(16'h0405);
      chk("cart_0405", cpu_q, 8'h05);
      cpu_write(16'h0405, 8'hEE);
      cpu_read(16'h0405);
      chk("cart_ro_0405", cpu_q, 8'h05);
      cpu_read(16'h0480);
      chk("cart_0480", cpu_q, 8'h80);

      // ---- DMA burst against a held CPU read
      for (int k = 0; k < 8; k++) cpu_write(16'h0900 + 16'(k), 8'h40 + 8'(k));
      cpu_rd = 1'b1; cpu_a = 16'h0000;
      for (int k = 0; k < 8; k++) begin
         dma_req = 1'b1; dma_a = 16'h0900 + 16'(k); #1;
         chk("dma_ack", dma_ack, 1'b1);
         chk("dma_cpu_wait", cpu_wait, 1'b1);
         chk("dma_cpu_q_hold", cpu_q, 8'h80);
         if (k == 0) chk("dma_valid_first", dma_valid, 1'b0);
         else begin
            chk("dma_valid", dma_valid, 1'b1);
            chk("dma_q", dma_q, 32'h40 + 32'(k - 1));
         end
         tick();
      end
      dma_req = 1'b0; #1;
      chk("dma_end_wait", cpu_wait, 1'b0);
      chk("dma_end_ack", dma_ack, 1'b0);
      chk("dma_last_valid", dma_valid, 1'b1);
      chk("dma_last_q", dma_q, 8'h47);
      tick(); cpu_rd = 1'b0;
      chk("cpu_after_dma", cpu_q, 8'h00);
      chk("dma_valid_drop", dma_valid, 1'b0);

      // ---- 256-byte cart with an out-of-range byte
      dl_start(8'h01);
      chk("reload_clr_loaded", cart_loaded, 1'b0);
      chk("reload_clr_len", cart_len, 0);
      for (int i = 0; i < 256; i++) dl_byte(25'(i), 8'(i));
      chk("len_256", cart_len, 256);
      dl_byte(25'd1024, 8'h99);
      chk("ovf_set", load_overflow, 1'b1);
      chk("ovf_len_kept", cart_len, 256);
      dl_end();
      chk("ovf_sticky", load_overflow, 1'b1);
      chk("cart256_loaded", cart_loaded, 1'b1);
      cpu_read(16'h0400);
      chk("ovf_no_alias", cpu_q, 8'h00);
      // Mirrored: offset 0x105 mod 256 = 5. Raw: offset 0x105 still holds
      // 0x05 from the 512-byte image. Either way the byte is 0x05.
      cpu_read(16'h0505);
      chk("cart_0505", cpu_q, 8'h05);
      cpu_read(16'hF000);
      chk("unmapped_f000", cpu_q, 8'hFF);

      // ---- BIOS download, then an ignored download
      dl_start(8'h00);
      dl_byte(25'd0, 8'h11);
      dl_byte(25'd1, 8'h22);
      dl_end();
      cpu_read(16'h0001);
      chk("bios_0001", cpu_q, 8'h22);
      chk("bios_keeps_cart", cart_loaded, 1'b1);
      ioctl_index = 8'h05; ioctl_download = 1'b1;
      tick();
      chk("bad_index_no_wait", cpu_wait, 1'b0);
      dl_byte(25'd0, 8'h77);
      ioctl_download = 1'b0;
      tick();
      cpu_read(16'h0000);
      chk("bad_index_ignored", cpu_q, 8'h11);

      // ---- reset in the middle of a cart download
      dl_start(8'h01);
      chk("restart_ovf_clr", load_overflow, 1'b0);
      dl_byte(25'd16, 8'hAB);
      chk("len_17", cart_len, 17);
      resetq = 1'b0; #1;
      chk("midrst_wait", cpu_wait, 1'b1);
      tick();
      chk("midrst_loaded", cart_loaded, 1'b0);
      chk("midrst_len", cart_len, 0);
      chk("midrst_cpu_q", cpu_q, 8'h00);
      chk("midrst_dma_q", dma_q, 8'h00);
      resetq = 1'b1;
      tick();
      chk("stale_dl_wait1", cpu_wait, 1'b1);
      tick();
      chk("stale_dl_wait2", cpu_wait, 1'b1);
      ioctl_download = 1'b0; #1;
      chk("stale_dl_fall", cpu_wait, 1'b0);
      tick();
      chk("stale_dl_idle", cpu_wait, 1'b0);
      cpu_read(16'h0810);
      chk("ram_kept", cpu_q, 8'hA5);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
